// File: rtl/hanoi_move_sequencer_if.sv
// Move bus between the Hanoi sequencer (master) and the tower datapath (slave).
interface hanoi_move_sequencer_if #(
  parameter int S = 4
) ();
  localparam int DW = $clog2(S);

  logic          mv_valid;
  logic          mv_ready;
  logic [1:0]    mv_fr;
  logic [1:0]    mv_to;
  logic [DW-1:0] mv_disk;

  modport master (output mv_valid, output mv_fr, output mv_to, output mv_disk, input mv_ready);
  modport slave  (input mv_valid, input mv_fr, input mv_to, input mv_disk, output mv_ready);
endinterface

// File: rtl/hanoi_move_sequencer.sv
// Issues the optimal Towers-of-Hanoi move sequence (tower 0 -> tower 2), one move per
// handshake, while checking every move against a shadow copy of tower occupancy.
module hanoi_move_sequencer #(
  parameter int S = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  hanoi_move_sequencer_if.master        mv,
  output logic                          busy,
  output logic                          done,
  output logic [S-1:0]                  move_cnt,
  output logic                          err
);
  localparam int DW = $clog2(S);
  localparam int KW = S + 1;
  localparam logic [KW-1:0] LAST_K = KW'((1 << S) - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state_r, state_s;
  logic [KW-1:0] k_r, k_s;
  logic [1:0]    fr_r, fr_s, to_r, to_s;
  logic [DW-1:0] disk_r, disk_s;
  logic          valid_r, valid_s, busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic [S-1:0]  cnt_r, cnt_s;
  logic [S-1:0]  t0_r, t0_s, t1_r, t1_s, t2_r, t2_s;
  logic [S-1:0]  bit_s, src_s, dst_s;
  logic          hs_s;

  // Raw tower code mod 3; even disk counts mirror towers 1 and 2 so the stack ends on tower 2.
  function automatic logic [1:0] tower(input logic [KW-1:0] v);
    logic [1:0] raw;
    raw = 2'(v % KW'(3));
    if ((S % 2 == 0) && (raw != 2'd0)) tower = 2'd3 - raw;
    else                               tower = raw;
  endfunction

  function automatic logic [1:0] move_fr(input logic [KW-1:0] k);
    move_fr = tower(k & (k - KW'(1)));
  endfunction

  function automatic logic [1:0] move_to(input logic [KW-1:0] k);
    move_to = tower((k | (k - KW'(1))) + KW'(1));
  endfunction

  function automatic logic [DW-1:0] move_disk(input logic [KW-1:0] k);
    logic [DW-1:0] tz;
    tz = {DW{1'b0}};
    for (int i = S - 1; i >= 0; i--) tz = k[i] ? DW'(i) : tz;
    move_disk = tz;
  endfunction

  function automatic logic [S-1:0] pick(input logic [1:0] code, input logic [S-1:0] a,
                                        input logic [S-1:0] b, input logic [S-1:0] c);
    case (code)
      2'd0:    pick = a;
      2'd1:    pick = b;
      2'd2:    pick = c;
      default: pick = {S{1'b0}};
    endcase
  endfunction

  // A disk must sit on top of its source and land on a smaller-free, not-already-holding tower.
  function automatic logic illegal(input logic [S-1:0] src, input logic [S-1:0] dst,
                                   input logic [S-1:0] onehot, input logic [1:0] fr,
                                   input logic [1:0] to);
    logic [S-1:0] below;
    below   = onehot - S'(1);
    illegal = ((src & onehot) == {S{1'b0}}) || ((src & below) != {S{1'b0}}) ||
              ((dst & below) != {S{1'b0}})  || ((dst & onehot) != {S{1'b0}}) || (fr == to);
  endfunction

  // Next-state, next-move and shadow-tower logic.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    fr_s    = fr_r;
    to_s    = to_r;
    disk_s  = disk_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    t0_s    = t0_r;
    t1_s    = t1_r;
    t2_s    = t2_r;
    hs_s    = valid_r & mv.mv_ready;
    bit_s   = S'(1) << disk_r;
    src_s   = pick(fr_r, t0_r, t1_r, t2_r);
    dst_s   = pick(to_r, t0_r, t1_r, t2_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ISSUE;
          k_s     = KW'(1);
          fr_s    = move_fr(KW'(1));
          to_s    = move_to(KW'(1));
          disk_s  = move_disk(KW'(1));
          cnt_s   = {S{1'b0}};
          err_s   = 1'b0;
          t0_s    = {S{1'b1}};
          t1_s    = {S{1'b0}};
          t2_s    = {S{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_s = IDLE;
        end else if (hs_s) begin
          cnt_s = cnt_r + S'(1);
          err_s = err_r | illegal(src_s, dst_s, bit_s, fr_r, to_r);
          case (fr_r)
            2'd0:    t0_s = t0_s & ~bit_s;
            2'd1:    t1_s = t1_s & ~bit_s;
            2'd2:    t2_s = t2_s & ~bit_s;
            default: t0_s = t0_s;
          endcase
          case (to_r)
            2'd0:    t0_s = t0_s | bit_s;
            2'd1:    t1_s = t1_s | bit_s;
            2'd2:    t2_s = t2_s | bit_s;
            default: t0_s = t0_s;
          endcase
          if (k_r == LAST_K) begin
            state_s = DONE;
          end else begin
            k_s    = k_r + KW'(1);
            fr_s   = move_fr(k_r + KW'(1));
            to_s   = move_to(k_r + KW'(1));
            disk_s = move_disk(k_r + KW'(1));
          end
        end else begin
          state_s = ISSUE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    valid_s = (state_s == ISSUE);
    busy_s  = (state_s == ISSUE);
    done_s  = (state_s == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= {KW{1'b0}};
      fr_r    <= 2'd0;
      to_r    <= 2'd0;
      disk_r  <= {DW{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= {S{1'b0}};
      err_r   <= 1'b0;
      t0_r    <= {S{1'b1}};
      t1_r    <= {S{1'b0}};
      t2_r    <= {S{1'b0}};
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      fr_r    <= fr_s;
      to_r    <= to_s;
      disk_r  <= disk_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      t0_r    <= t0_s;
      t1_r    <= t1_s;
      t2_r    <= t2_s;
    end
  end

  assign mv.mv_valid = valid_r;
  assign mv.mv_fr    = fr_r;
  assign mv.mv_to    = to_r;
  assign mv.mv_disk  = disk_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign move_cnt    = cnt_r;
  assign err         = err_r;
endmodule

// File: tb/tb_hanoi_move_sequencer.sv
// Directed bench for hanoi_move_sequencer with S=2, 3 and 4 instances.
module tb_hanoi_move_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st2, ab2, busy2, done2, err2;
  logic [1:0] cnt2;
  logic st3, ab3, busy3, done3, err3;
  logic [2:0] cnt3;
  logic st4, ab4, busy4, done4, err4;
  logic [3:0] cnt4;

  hanoi_move_sequencer_if #(.S(2)) if2 ();
  hanoi_move_sequencer_if #(.S(3)) if3 ();
  hanoi_move_sequencer_if #(.S(4)) if4 ();

  hanoi_move_sequencer #(.S(2)) u2 (.clk(clk), .rst(rst), .start(st2), .abort(ab2), .mv(if2),
                                    .busy(busy2), .done(done2), .move_cnt(cnt2), .err(err2));
  hanoi_move_sequencer #(.S(3)) u3 (.clk(clk), .rst(rst), .start(st3), .abort(ab3), .mv(if3),
                                    .busy(busy3), .done(done3), .move_cnt(cnt3), .err(err3));
  hanoi_move_sequencer #(.S(4)) u4 (.clk(clk), .rst(rst), .start(st4), .abort(ab4), .mv(if4),
                                    .busy(busy4), .done(done4), .move_cnt(cnt4), .err(err4));

  int checks = 0;
  int failures = 0;

  logic [1:0] fr2_e [3] = '{2'd0, 2'd0, 2'd1};
  logic [1:0] to2_e [3] = '{2'd1, 2'd2, 2'd2};
  logic [0:0] d2_e  [3] = '{1'd0, 1'd1, 1'd0};
  logic [1:0] fr3_e [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
  logic [1:0] to3_e [7] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2};
  logic [1:0] d3_e  [7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
  logic [1:0] fr4_e [15] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0,
                             2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1};
  logic [1:0] to4_e [15] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2,
                             2'd2, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2};
  logic [1:0] d4_e  [15] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                             2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({if4.mv_valid, if4.mv_fr, if4.mv_to, if4.mv_disk, busy4, done4, cnt4, err4} !== 14'd0) begin
      failures++;
      $display("FAIL reset_s4_outputs got=%b required=0", {if4.mv_valid, if4.mv_fr, if4.mv_to, if4.mv_disk, busy4, done4, cnt4, err4});
    end
    checks++;
    if ({u4.t0_r, u4.t1_r, u4.t2_r} !== {4'b1111, 4'b0000, 4'b0000}) begin
      failures++;
      $display("FAIL reset_s4_shadow got=%b required=%b", {u4.t0_r, u4.t1_r, u4.t2_r}, {4'b1111, 8'b0});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic run_s3(input int pulse_at, input string tag);
    if3.mv_ready = 1'b1;
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({if3.mv_valid, busy3, if3.mv_fr, if3.mv_to, if3.mv_disk} !== {1'b1, 1'b1, fr3_e[i], to3_e[i], d3_e[i]}) begin
        failures++;
        $display("FAIL %s_move%0d got=%b required=%b", tag, i + 1,
                 {if3.mv_valid, busy3, if3.mv_fr, if3.mv_to, if3.mv_disk}, {1'b1, 1'b1, fr3_e[i], to3_e[i], d3_e[i]});
      end
      st3 = (i == pulse_at);
      tick();
      st3 = 1'b0;
    end
    checks++;
    if ({done3, busy3, if3.mv_valid, cnt3, err3} !== {1'b1, 1'b0, 1'b0, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL %s_done got=%b required=%b", tag, {done3, busy3, if3.mv_valid, cnt3, err3}, {3'b100, 3'd7, 1'b0});
    end
    tick();
    checks++;
    if ({done3, busy3, if3.mv_valid, cnt3} !== {3'b000, 3'd7}) begin
      failures++;
      $display("FAIL %s_idle_after got=%b required=%b", tag, {done3, busy3, if3.mv_valid, cnt3}, {3'b000, 3'd7});
    end
  endtask

  task automatic test_s3_sequence();
    run_s3(-1, "s3");
  endtask

  task automatic test_start_ignored();
    run_s3(2, "s3_start_in_issue");
  endtask

  task automatic test_s2_sequence();
    if2.mv_ready = 1'b1;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({if2.mv_valid, if2.mv_fr, if2.mv_to, if2.mv_disk} !== {1'b1, fr2_e[i], to2_e[i], d2_e[i]}) begin
        failures++;
        $display("FAIL s2_move%0d got=%b required=%b", i + 1,
                 {if2.mv_valid, if2.mv_fr, if2.mv_to, if2.mv_disk}, {1'b1, fr2_e[i], to2_e[i], d2_e[i]});
      end
      tick();
    end
    checks++;
    if ({done2, if2.mv_valid, cnt2, err2} !== {1'b1, 1'b0, 2'd3, 1'b0}) begin
      failures++;
      $display("FAIL s2_done got=%b required=%b", {done2, if2.mv_valid, cnt2, err2}, {2'b10, 2'd3, 1'b0});
    end
    tick();
  endtask

  task automatic test_back_to_back_stall();
    int idx = 0;
    int cyc = 0;
    if4.mv_ready = 1'b0;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    while (idx < 15 && cyc < 400) begin
      checks++;
      if ({if4.mv_valid, busy4, if4.mv_fr, if4.mv_to, if4.mv_disk} !== {1'b1, 1'b1, fr4_e[idx], to4_e[idx], d4_e[idx]}) begin
        failures++;
        $display("FAIL s4_stall_move%0d cycle%0d got=%b required=%b", idx + 1, cyc,
                 {if4.mv_valid, busy4, if4.mv_fr, if4.mv_to, if4.mv_disk}, {1'b1, 1'b1, fr4_e[idx], to4_e[idx], d4_e[idx]});
      end
      if4.mv_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (if4.mv_ready) idx++;
    end
    checks++;
    if (idx != 15) begin
      failures++;
      $display("FAIL s4_stall_timeout got=%0d moves required=15", idx);
    end
    checks++;
    if ({done4, if4.mv_valid, cnt4, err4} !== {1'b1, 1'b0, 4'd15, 1'b0}) begin
      failures++;
      $display("FAIL s4_stall_done got=%b required=%b", {done4, if4.mv_valid, cnt4, err4}, {2'b10, 4'd15, 1'b0});
    end
    checks++;
    if ({u4.t0_r, u4.t1_r, u4.t2_r} !== {4'b0000, 4'b0000, 4'b1111}) begin
      failures++;
      $display("FAIL s4_final_shadow got=%b required=%b", {u4.t0_r, u4.t1_r, u4.t2_r}, {8'b0, 4'b1111});
    end
    if4.mv_ready = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    if4.mv_ready = 1'b1;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({if4.mv_valid, if4.mv_fr, if4.mv_to, if4.mv_disk, cnt4} !== {1'b1, 2'd2, 2'd0, 2'd0, 4'd4}) begin
      failures++;
      $display("FAIL abort_move5_offer got=%b required=%b", {if4.mv_valid, if4.mv_fr, if4.mv_to, if4.mv_disk, cnt4}, {1'b1, 6'b100000, 4'd4});
    end
    ab4 = 1'b1;
    tick();
    ab4 = 1'b0;
    checks++;
    if ({if4.mv_valid, busy4, done4, cnt4} !== {3'b000, 4'd4}) begin
      failures++;
      $display("FAIL abort_idle got=%b required=%b", {if4.mv_valid, busy4, done4, cnt4}, {3'b000, 4'd4});
    end
    tick();
    checks++;
    if ({done4, busy4, cnt4} !== {2'b00, 4'd4}) begin
      failures++;
      $display("FAIL abort_no_done got=%b required=%b", {done4, busy4, cnt4}, {2'b00, 4'd4});
    end
    st4 = 1'b1;
    ab4 = 1'b1;
    tick();
    st4 = 1'b0;
    ab4 = 1'b0;
    checks++;
    if ({if4.mv_valid, busy4, if4.mv_fr, if4.mv_to, if4.mv_disk, cnt4} !== {2'b11, 2'd0, 2'd1, 2'd0, 4'd0}) begin
      failures++;
      $display("FAIL abort_restart got=%b required=%b", {if4.mv_valid, busy4, if4.mv_fr, if4.mv_to, if4.mv_disk, cnt4}, {2'b11, 6'b000100, 4'd0});
    end
    ab4 = 1'b1;
    tick();
    ab4 = 1'b0;
    checks++;
    if ({if4.mv_valid, busy4, cnt4} !== {2'b00, 4'd0}) begin
      failures++;
      $display("FAIL abort_restart_cancel got=%b required=%b", {if4.mv_valid, busy4, cnt4}, 6'd0);
    end
  endtask

  task automatic test_rst_midrun();
    if3.mv_ready = 1'b1;
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({if3.mv_valid, if3.mv_fr, if3.mv_to, if3.mv_disk, busy3, done3, cnt3, err3} !== 13'd0) begin
      failures++;
      $display("FAIL rst_midrun_outputs got=%b required=0", {if3.mv_valid, if3.mv_fr, if3.mv_to, if3.mv_disk, busy3, done3, cnt3, err3});
    end
    checks++;
    if ({u3.t0_r, u3.t1_r, u3.t2_r} !== {3'b111, 3'b000, 3'b000}) begin
      failures++;
      $display("FAIL rst_midrun_shadow got=%b required=%b", {u3.t0_r, u3.t1_r, u3.t2_r}, 9'b111000000);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_err_hook();
    if3.mv_ready = 1'b1;
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    checks++;
    if (err3 !== 1'b0) begin
      failures++;
      $display("FAIL err_hook_pre got=%b required=0", err3);
    end
    force u3.t2_r = 3'b001;
    tick();
    release u3.t2_r;
    checks++;
    if ({err3, if3.mv_fr, if3.mv_to, if3.mv_disk} !== {1'b1, 2'd0, 2'd1, 2'd1}) begin
      failures++;
      $display("FAIL err_hook_set got=%b required=%b", {err3, if3.mv_fr, if3.mv_to, if3.mv_disk}, 7'b1000101);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if ({done3, err3, cnt3} !== {2'b11, 3'd7}) begin
      failures++;
      $display("FAIL err_hook_sticky got=%b required=%b", {done3, err3, cnt3}, {2'b11, 3'd7});
    end
    tick();
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    checks++;
    if ({err3, if3.mv_valid, cnt3} !== {2'b01, 3'd0}) begin
      failures++;
      $display("FAIL err_hook_cleared got=%b required=%b", {err3, if3.mv_valid, cnt3}, {2'b01, 3'd0});
    end
    ab3 = 1'b1;
    tick();
    ab3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {st2, ab2, st3, ab3, st4, ab4} = 6'd0;
    if2.mv_ready = 1'b0;
    if3.mv_ready = 1'b0;
    if4.mv_ready = 1'b0;
    test_reset();
    test_s3_sequence();
    test_s2_sequence();
    test_back_to_back_stall();
    test_abort();
    test_start_ignored();
    test_rst_midrun();
    test_err_hook();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
